cpu_seq_ctrl: RTL and testbench

- Fetch/execute sequencer for the 8-bit CPU.
- Drives the 16x8 program/data memory (combinational read, level-sensitive active-low store strobe) and the accumulator/ALU datapath.
- Each instruction is two bytes, opcode then operand, except HALT (1 byte). Opcodes: LD 0x10, ADD 0x11, SUB 0x12, AND 0x13, OR 0x14, STO 0x15, HALT 0x16.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/cpu_seq_decode.sv | 32 +++
 rtl/cpu_seq_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_cpu_seq_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU fetch/execute sequencer:
// default widths, opcode and ALU encodings, the sequencer state
// encoding and an opcode legality helper.
package cpu_pkg;

    localparam int CPU_AW = 4;
    localparam int CPU_DW = 8;

    localparam logic [7:0] OP_LD   = 8'h10;
    localparam logic [7:0] OP_ADD  = 8'h11;
    localparam logic [7:0] OP_SUB  = 8'h12;
    localparam logic [7:0] OP_AND  = 8'h13;
    localparam logic [7:0] OP_OR   = 8'h14;
    localparam logic [7:0] OP_STO  = 8'h15;
    localparam logic [7:0] OP_HALT = 8'h16;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH_OP  = 3'd1,
        ST_FETCH_ARG = 3'd2,
        ST_EXEC      = 3'd3,
        ST_HALT      = 3'd4
    } state_t;

    // An opcode is legal only in the 0x10..0x16 window.
    function automatic logic op_is_illegal(input logic [7:0] op);
        return (op[7:4] != 4'h1) || (op[3:0] > 4'h6);
    endfunction

endpackage

// File: rtl/cpu_seq_decode.sv
// Combinational instruction decoder for the sequencer: classifies an
// opcode byte as ALU op, store, halt or illegal and yields the ALU code.
module cpu_seq_decode
    import cpu_pkg::*;
(
    input  logic [7:0] opcode,
    output logic       is_alu,
    output logic       is_sto,
    output logic       is_halt,
    output logic       is_illegal,
    output logic [2:0] alu_op
);

    // Opcode classification; ALU codes are the low three opcode bits.
    always_comb begin
        is_alu     = 1'b0;
        is_sto     = 1'b0;
        is_halt    = 1'b0;
        alu_op     = ALU_PASS;
        is_illegal = op_is_illegal(opcode);
        case (opcode)
            OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                is_alu = 1'b1;
                alu_op = opcode[2:0];
            end
            OP_STO:  is_sto  = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Fetch/execute sequencer for the 8-bit CPU. Fetches a two-byte
// instruction (opcode, operand) from the 16x8 memory, then spends one
// EXEC cycle either loading the accumulator or pulsing the store strobe.
// HALT is a single-byte instruction that parks the block until rst.
//
// Optional build macro CPU_SEQ_ILLEGAL_TRAP_EN: when defined, opcodes
// outside 0x10..0x16 trap to HALT and raise the sticky 'illegal' output;
// when undefined they run as two-byte NOPs and 'illegal' does not exist.
//
// acc_we, alu_op and mem_sto_n are registered so that no path exists
// from mem_data to any output; mem_addr is selected by flops only.
module cpu_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int AW = CPU_AW,
    parameter int DW = CPU_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic [DW-1:0] mem_data,
    input  logic [DW-1:0] acc_in,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_sto_n,
    output logic [2:0]    alu_op,
    output logic [DW-1:0] operand,
    output logic          acc_we,
    output logic          halted,
    output logic [AW-1:0] pc
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
    ,
    output logic          illegal
`endif
);

    localparam logic [AW-1:0] PC_STEP = {{(AW-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [DW-1:0] operand_q, operand_d;
    logic          mem_sto_n_q, mem_sto_n_d;
    logic          acc_we_q, acc_we_d;
    logic [2:0]    alu_op_q, alu_op_d;

    logic          dec_is_alu;
    logic          dec_is_sto;
    logic          dec_is_halt;
    logic          dec_is_illegal;
    logic [2:0]    dec_alu_op;

`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
    logic          illegal_q, illegal_d;
`endif

    // The decoder looks at the byte being fetched during FETCH_OP and at
    // the latched instruction register otherwise.
    always_comb begin
        ir_d = ir_q;
        if (state_q == ST_FETCH_OP) begin
            ir_d = mem_data;
        end
    end

    cpu_seq_decode u_decode (
        .opcode     (ir_d[7:0]),
        .is_alu     (dec_is_alu),
        .is_sto     (dec_is_sto),
        .is_halt    (dec_is_halt),
        .is_illegal (dec_is_illegal),
        .alu_op     (dec_alu_op)
    );

    // Next-state, program counter and operand latch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        operand_d = operand_q;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH_OP;
                end
            end
            ST_FETCH_OP: begin
                pc_d = pc_q + PC_STEP;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
                if (dec_is_illegal) begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end else if (dec_is_halt) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH_ARG;
                end
`else
                if (dec_is_halt) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH_ARG;
                end
`endif
            end
            ST_FETCH_ARG: begin
                operand_d = mem_data;
                pc_d      = pc_q + PC_STEP;
                state_d   = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = run ? ST_FETCH_OP : ST_IDLE;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath strobes are computed one cycle ahead so they come straight
    // out of flops while EXEC is the current state; an illegal byte that
    // reaches EXEC never drives either strobe.
    always_comb begin
        acc_we_d    = 1'b0;
        alu_op_d    = ALU_PASS;
        mem_sto_n_d = 1'b1;
        if ((state_d == ST_EXEC) && !dec_is_illegal) begin
            if (dec_is_alu) begin
                acc_we_d = 1'b1;
                alu_op_d = dec_alu_op;
            end else if (dec_is_sto) begin
                mem_sto_n_d = 1'b0;
            end
        end
    end

    // Sequencer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            operand_q   <= '0;
            mem_sto_n_q <= 1'b1;
            acc_we_q    <= 1'b0;
            alu_op_q    <= ALU_PASS;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            operand_q   <= operand_d;
            mem_sto_n_q <= mem_sto_n_d;
            acc_we_q    <= acc_we_d;
            alu_op_q    <= alu_op_d;
        end
    end

`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
    // Sticky illegal-opcode flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
`endif

    // Address mux: the store target is held for the whole strobe-low
    // cycle, otherwise memory follows the program counter.
    always_comb begin
        mem_addr = pc_q;
        if (!mem_sto_n_q) begin
            mem_addr = operand_q[AW-1:0];
        end
    end

    assign mem_wdata = acc_in;
    assign mem_sto_n = mem_sto_n_q;
    assign acc_we    = acc_we_q;
    assign alu_op    = alu_op_q;
    assign operand   = operand_q;
    assign pc        = pc_q;
    assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Self-checking bench for cpu_seq_ctrl. A small memory and accumulator
// datapath surround the DUT; an instruction-level model of the CPU
// predicts bus activity cycle by cycle for directed and random programs.
`timescale 1ns/1ps
module tb_cpu_seq_ctrl;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [7:0] mem_data;
    logic [7:0] acc_in;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_sto_n;
    logic [2:0] alu_op;
    logic [7:0] operand;
    logic       acc_we;
    logic       halted;
    logic [3:0] pc;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    // Environment: program/data memory and accumulator.
    logic [7:0] env_mem [16];
    logic [7:0] env_acc;
    logic       mem_load = 1'b0;
    logic [3:0] load_addr = '0;
    logic [7:0] load_val = '0;
    logic       acc_load = 1'b0;
    logic [7:0] acc_load_val = '0;

    // Reference model state.
    logic [7:0] prog [16];
    logic [7:0] model_mem [16];
    logic [7:0] model_acc;
    logic [3:0] model_pc;
    bit         stopped;

    cpu_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .mem_data  (mem_data),
        .acc_in    (acc_in),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_sto_n (mem_sto_n),
        .alu_op    (alu_op),
        .operand   (operand),
        .acc_we    (acc_we),
        .halted    (halted),
        .pc        (pc)
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        ,
        .illegal   (illegal)
`endif
    );

    always #5 clk = ~clk;

    assign mem_data = env_mem[mem_addr];
    assign acc_in   = env_acc;

    // Memory: bench loading has priority, otherwise the store strobe
    // writes at the end of its low cycle.
    always @(posedge clk) begin
        if (mem_load) begin
            env_mem[load_addr] <= load_val;
        end else if (!mem_sto_n) begin
            env_mem[mem_addr] <= mem_wdata;
        end
    end

    // Accumulator datapath.
    always @(posedge clk) begin
        if (acc_load) begin
            env_acc <= acc_load_val;
        end else if (acc_we) begin
            case (alu_op)
                3'd0:    env_acc <= operand;
                3'd1:    env_acc <= env_acc + operand;
                3'd2:    env_acc <= env_acc - operand;
                3'd3:    env_acc <= env_acc & operand;
                3'd4:    env_acc <= env_acc | operand;
                default: env_acc <= 8'hxx;
            endcase
        end
    end

    function automatic logic [7:0] modelAlu(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            8'h10:   return b;
            8'h11:   return a + b;
            8'h12:   return a - b;
            8'h13:   return a & b;
            8'h14:   return a | b;
            default: return a;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Hold reset, load prog[] and the accumulator, release reset and
    // leave the DUT idle (sampled on a falling edge).
    task automatic applyStimulus(input logic [7:0] start_acc);
        rst = 1'b1;
        run = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            mem_load  = 1'b1;
            load_addr = i[3:0];
            load_val  = prog[i];
        end
        @(negedge clk);
        mem_load     = 1'b0;
        acc_load     = 1'b1;
        acc_load_val = start_acc;
        @(negedge clk);
        acc_load = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_mem = prog;
        model_acc = start_acc;
        model_pc  = 4'd0;
    endtask

    task automatic startRun();
        run = 1'b1;
        @(negedge clk);
    endtask

    // Execute one instruction from its FETCH_OP cycle. pause_mode drops
    // run in FETCH_OP (1), FETCH_ARG (2) or EXEC (3), then idles three
    // cycles and resumes. Returns with the DUT in the next FETCH_OP.
    task automatic runInstruction(input int pause_mode, output bit halted_now);
        logic [7:0] op;
        logic [7:0] arg;
        bit         trap;
        halted_now = 1'b0;
        checkOutput("fop_addr", mem_addr, model_pc);
        checkOutput("fop_pc", pc, model_pc);
        checkOutput("fop_acc_we", acc_we, 1'b0);
        checkOutput("fop_sto_n", mem_sto_n, 1'b1);
        checkOutput("fop_alu_op", alu_op, 3'd0);
        checkOutput("fop_halted", halted, 1'b0);
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        checkOutput("fop_illegal", illegal, 1'b0);
`endif
        op       = model_mem[model_pc];
        model_pc = model_pc + 4'd1;
        trap     = 1'b0;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        trap = (op < 8'h10) || (op > 8'h16);
`endif
        if (pause_mode == 1) run = 1'b0;
        @(negedge clk);
        if (op == 8'h16 || trap) begin
            checkOutput("halt_flag", halted, 1'b1);
            checkOutput("halt_pc", pc, model_pc);
            checkOutput("halt_addr", mem_addr, model_pc);
            checkOutput("halt_acc_we", acc_we, 1'b0);
            checkOutput("halt_sto_n", mem_sto_n, 1'b1);
            checkOutput("halt_alu_op", alu_op, 3'd0);
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
            checkOutput("halt_illegal", illegal, trap);
`endif
            halted_now = 1'b1;
            return;
        end
        checkOutput("farg_addr", mem_addr, model_pc);
        checkOutput("farg_acc_we", acc_we, 1'b0);
        checkOutput("farg_sto_n", mem_sto_n, 1'b1);
        arg      = model_mem[model_pc];
        model_pc = model_pc + 4'd1;
        if (pause_mode == 2) run = 1'b0;
        @(negedge clk);
        checkOutput("exec_pc", pc, model_pc);
        checkOutput("exec_operand", operand, arg);
        checkOutput("exec_wdata", mem_wdata, model_acc);
        checkOutput("exec_halted", halted, 1'b0);
        if (op >= 8'h10 && op <= 8'h14) begin
            checkOutput("exec_acc_we", acc_we, 1'b1);
            checkOutput("exec_alu_op", alu_op, op - 8'h10);
            checkOutput("exec_sto_n", mem_sto_n, 1'b1);
            checkOutput("exec_addr", mem_addr, model_pc);
            model_acc = modelAlu(op, model_acc, arg);
        end else if (op == 8'h15) begin
            checkOutput("sto_sto_n", mem_sto_n, 1'b0);
            checkOutput("sto_addr", mem_addr, arg[3:0]);
            checkOutput("sto_acc_we", acc_we, 1'b0);
            checkOutput("sto_alu_op", alu_op, 3'd0);
            model_mem[arg[3:0]] = model_acc;
        end else begin
            checkOutput("nop_acc_we", acc_we, 1'b0);
            checkOutput("nop_sto_n", mem_sto_n, 1'b1);
            checkOutput("nop_alu_op", alu_op, 3'd0);
            checkOutput("nop_addr", mem_addr, model_pc);
        end
        if (pause_mode == 3) run = 1'b0;
        if (pause_mode != 0) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                checkOutput("idle_addr", mem_addr, model_pc);
                checkOutput("idle_pc", pc, model_pc);
                checkOutput("idle_acc_we", acc_we, 1'b0);
                checkOutput("idle_sto_n", mem_sto_n, 1'b1);
                checkOutput("idle_halted", halted, 1'b0);
            end
            run = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        $display("[TB] cpu_seq_ctrl bench starting");

        // Reset state and LD/ADD timing.
        for (int i = 0; i < 16; i++) prog[i] = 8'h16;
        prog[0] = 8'h10; prog[1] = 8'h05; prog[2] = 8'h11; prog[3] = 8'h06;
        applyStimulus(8'h00);
        checkOutput("rst_addr", mem_addr, 4'h0);
        checkOutput("rst_sto_n", mem_sto_n, 1'b1);
        checkOutput("rst_acc_we", acc_we, 1'b0);
        checkOutput("rst_halted", halted, 1'b0);
        checkOutput("rst_pc", pc, 4'h0);
        checkOutput("rst_alu_op", alu_op, 3'd0);
        checkOutput("rst_operand", operand, 8'h00);
        repeat (2) @(negedge clk);
        checkOutput("idle_hold_pc", pc, 4'h0);
        startRun();
        runInstruction(0, stopped);
        runInstruction(0, stopped);
        checkOutput("ldadd_pc", pc, 4'h4);
        checkOutput("ldadd_acc", acc_in, 8'h0B);
        runInstruction(0, stopped);
        checkOutput("ldadd_halt", stopped, 1'b1);

        // Store strobe.
        for (int i = 0; i < 16; i++) prog[i] = 8'h16;
        prog[0] = 8'h15; prog[1] = 8'h0F;
        applyStimulus(8'hA5);
        startRun();
        runInstruction(0, stopped);
        checkOutput("sto_mem15", env_mem[15], 8'hA5);
        runInstruction(0, stopped);

        // Reset during a store EXEC.
        applyStimulus(8'h3C);
        startRun();
        repeat (2) @(negedge clk);
        checkOutput("rstx_sto_low", mem_sto_n, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rstx_sto_n", mem_sto_n, 1'b1);
        checkOutput("rstx_pc", pc, 4'h0);
        checkOutput("rstx_addr", mem_addr, 4'h0);

        // HALT at address 0; run toggling is ignored, rst exits.
        for (int i = 0; i < 16; i++) prog[i] = 8'h10;
        prog[0] = 8'h16;
        applyStimulus(8'h00);
        startRun();
        runInstruction(0, stopped);
        checkOutput("halt0_pc", pc, 4'h1);
        for (int k = 0; k < 6; k++) begin
            run = k[0];
            @(negedge clk);
            checkOutput("halt_sticky", halted, 1'b1);
            checkOutput("halt_pc_hold", pc, 4'h1);
        end
        rst = 1'b1;
        run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("halt_rst_flag", halted, 1'b0);
        checkOutput("halt_rst_pc", pc, 4'h0);

        // Eight ALU instructions filling memory: pc wraps and refetches.
        for (int i = 0; i < 8; i++) begin
            prog[2*i]   = 8'h10 + 8'($urandom_range(0, 4));
            prog[2*i+1] = 8'($urandom_range(0, 255));
        end
        prog[0] = 8'h10;
        applyStimulus(8'h00);
        startRun();
        for (int i = 0; i < 8; i++) runInstruction(0, stopped);
        checkOutput("wrap_pc", pc, 4'h0);
        checkOutput("wrap_refetch", mem_data, 8'h10);
        checkOutput("wrap_acc", acc_in, model_acc);

        // run dropped during FETCH_ARG, then resumed.
        for (int i = 0; i < 16; i++) prog[i] = 8'h16;
        prog[0] = 8'h10; prog[1] = 8'h33; prog[2] = 8'h11; prog[3] = 8'h01;
        prog[4] = 8'h12; prog[5] = 8'h02;
        applyStimulus(8'h00);
        startRun();
        runInstruction(2, stopped);
        checkOutput("resume_pc", pc, 4'h2);
        runInstruction(0, stopped);
        runInstruction(0, stopped);
        checkOutput("resume_acc", acc_in, 8'h32);

`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        // Illegal opcode trap.
        for (int i = 0; i < 16; i++) prog[i] = 8'h10;
        prog[0] = 8'h27;
        applyStimulus(8'h00);
        startRun();
        runInstruction(0, stopped);
        checkOutput("trap_halted", halted, 1'b1);
        checkOutput("trap_illegal", illegal, 1'b1);
`endif

        // Random programs with random pauses and self-modifying stores.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 8; i++) begin
                int r;
                r = int'($urandom_range(0, 19));
                if (r < 10)       prog[2*i] = 8'h10 + 8'($urandom_range(0, 4));
                else if (r < 14)  prog[2*i] = 8'h15;
                else if (r < 16)  prog[2*i] = 8'($urandom_range(0, 255));
                else if (r == 16) prog[2*i] = 8'h16;
                else              prog[2*i] = 8'h10 + 8'($urandom_range(0, 4));
                prog[2*i+1] = 8'($urandom_range(0, 255));
            end
            applyStimulus(8'($urandom_range(0, 255)));
            startRun();
            stopped = 1'b0;
            for (int n = 0; n < 30 && !stopped; n++) begin
                int pm;
                pm = int'($urandom_range(0, 9));
                runInstruction((pm <= 3) ? pm : 0, stopped);
            end
            checkOutput("rand_acc", acc_in, model_acc);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
